// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: default address width, reset
// address, the address typedef and the next-address source encoding.
package pc_pkg;

    // Default instruction address width and the address loaded on reset.
    localparam int PC_W   = 5;
    localparam int RST_PC = 0;

    // Instruction address at the default width.
    typedef logic [PC_W-1:0] pc_addr_t;

    // Source of the next program counter value.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_JUMP = 2'd1,
        SEL_WRAP = 2'd2,
        SEL_INC  = 2'd3
    } next_sel_e;

    // Choose the next-address source from the control inputs. Priority is
    // hold, then jump, then wrap, then sequential increment.
    function automatic next_sel_e pick_next(
        input logic pc_en,
        input logic jump_en,
        input logic at_bottom
    );
        if (!pc_en) begin
            return SEL_HOLD;
        end
        if (jump_en) begin
            return SEL_JUMP;
        end
        if (at_bottom) begin
            return SEL_WRAP;
        end
        return SEL_INC;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-address selection for program_counter.
// Build option: define PC_WRAP_EN to make a sequential advance from
// wrap_bottom return to wrap_top. Without it the window inputs are ignored
// and the counter simply increments modulo 2^PC_W except on a jump.
module pc_next
    import pc_pkg::*;
#(
    parameter int PC_W = pc_pkg::PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] wrap_top,
    input  logic [PC_W-1:0] wrap_bottom,
    input  logic [PC_W-1:0] jump,
    input  logic            jump_en,
    input  logic            pc_en,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] inc_pc;
    logic            at_bottom;
    next_sel_e       sel;

    // Sequential successor; the natural overflow gives the modulo wrap.
    assign inc_pc = pc + 1'b1;

`ifdef PC_WRAP_EN
    // Wrap only on an exact match with the window end; an address outside
    // the window keeps counting until it lands on wrap_bottom.
    assign at_bottom = (pc == wrap_bottom);
`else
    // Window inputs have no effect in this build.
    logic unused_window;
    assign unused_window = ^{wrap_top, wrap_bottom};
    assign at_bottom     = 1'b0;
`endif

    // Pick the next-address source and drive the selected value.
    always_comb begin
        sel     = pick_next(pc_en, jump_en, at_bottom);
        next_pc = pc;
        case (sel)
            SEL_HOLD: next_pc = pc;
            SEL_JUMP: next_pc = jump;
`ifdef PC_WRAP_EN
            SEL_WRAP: next_pc = wrap_top;
`else
            SEL_WRAP: next_pc = inc_pc;
`endif
            SEL_INC:  next_pc = inc_pc;
            default:  next_pc = pc;
        endcase
    end

endmodule

// File: rtl/program_counter.sv
// Program counter register with asynchronous active-high reset.
// Next-address selection (hold / jump / wrap / increment) is done in pc_next.
// Build option: PC_WRAP_EN enables the wrap_top/wrap_bottom program window.
module program_counter
    import pc_pkg::*;
#(
    parameter int PC_W   = pc_pkg::PC_W,
    parameter int RST_PC = pc_pkg::RST_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] wrap_top,
    input  logic [PC_W-1:0] wrap_bottom,
    input  logic [PC_W-1:0] jump,
    input  logic            jump_en,
    input  logic            pc_en,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] RST_VAL = PC_W'(RST_PC);

    logic [PC_W-1:0] next_pc;

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc          (pc),
        .wrap_top    (wrap_top),
        .wrap_bottom (wrap_bottom),
        .jump        (jump),
        .jump_en     (jump_en),
        .pc_en       (pc_en),
        .next_pc     (next_pc)
    );

    // PC register: reset forces the start address at once, otherwise load the
    // selected next address on each rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RST_VAL;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver applies one set of inputs
// per cycle and queues the pc value expected after the next rising edge; an
// independent monitor pops and compares just after each edge. Expectations
// for the window cases follow the PC_WRAP_EN build option.
module tb_program_counter;

    localparam int W = 5;

    typedef struct {
        string          name;
        logic [W-1:0]   val;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] wrap_top;
    logic [W-1:0] wrap_bottom;
    logic [W-1:0] jump;
    logic         jump_en;
    logic         pc_en;
    logic [W-1:0] pc;

    int   checks;
    int   errors;
    exp_t sb[$];

    program_counter #(
        .PC_W   (W),
        .RST_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wrap_top    (wrap_top),
        .wrap_bottom (wrap_bottom),
        .jump        (jump),
        .jump_en     (jump_en),
        .pc_en       (pc_en),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: pc=%0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input string name, input logic [W-1:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs after the edge and queue the post-edge result.
    task automatic step(input string name, input logic en, input logic je,
                        input logic [W-1:0] j, input logic [W-1:0] t,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
        @(posedge clk);
        #2;
        pc_en       = en;
        jump_en     = je;
        jump        = j;
        wrap_top    = t;
        wrap_bottom = b;
        push(name, exp);
    endtask

    // Monitor: compare pc against the oldest expectation just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, pc, e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        pc_en       = 1'b0;
        jump_en     = 1'b0;
        jump        = '0;
        wrap_top    = '0;
        wrap_bottom = 5'd31;

        #1;
        check("reset_state", pc, 5'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Free run over the full range: 1..31 then back to 0.
        for (int i = 1; i <= 32; i++) begin
            step("free_run", 1'b1, 1'b0, 5'd0, 5'd0, 5'd31, W'(i % 32));
        end

        // Jump with one-cycle latency, then sequential advance.
        step("jump_to_3",   1'b1, 1'b1, 5'd3,  5'd0, 5'd31, 5'd3);
        step("jump_to_12",  1'b1, 1'b1, 5'd12, 5'd0, 5'd31, 5'd12);
        step("after_jump",  1'b1, 1'b0, 5'd12, 5'd0, 5'd31, 5'd13);

        // Stall holds pc even with a jump request present; then jump beats wrap.
        step("jump_to_6",   1'b1, 1'b1, 5'd6,  5'd4, 5'd7,  5'd6);
        step("stall_1",     1'b0, 1'b1, 5'd25, 5'd4, 5'd7,  5'd6);
        step("stall_2",     1'b0, 1'b1, 5'd25, 5'd4, 5'd7,  5'd6);
        step("stall_3",     1'b0, 1'b0, 5'd25, 5'd4, 5'd7,  5'd6);
        step("to_bottom",   1'b1, 1'b0, 5'd25, 5'd4, 5'd7,  5'd7);
        step("jump_at_bot", 1'b1, 1'b1, 5'd2,  5'd4, 5'd7,  5'd2);

        // Window 4..7 starting at 4.
        step("win_start",   1'b1, 1'b1, 5'd4,  5'd4, 5'd7,  5'd4);
        step("win_5",       1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd5);
        step("win_6",       1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd6);
        step("win_7",       1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd7);
`ifdef PC_WRAP_EN
        step("win_wrap",    1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd4);
        step("win_after",   1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd5);
`else
        step("win_nowrap",  1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd8);
        step("win_after",   1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd9);
`endif

        // Outside the window: count up through the overflow into the window.
        step("oow_jump",    1'b1, 1'b1, 5'd20, 5'd4, 5'd7,  5'd20);
        for (int i = 21; i <= 39; i++) begin
            step("oow_run", 1'b1, 1'b0, 5'd0, 5'd4, 5'd7, W'(i % 32));
        end
`ifdef PC_WRAP_EN
        step("oow_wrap",    1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd4);
`else
        step("oow_nowrap",  1'b1, 1'b0, 5'd0,  5'd4, 5'd7,  5'd8);
`endif

        // Inverted window (top above bottom) is still legal.
        step("inv_jump",    1'b1, 1'b1, 5'd1,  5'd10, 5'd2, 5'd1);
        step("inv_bottom",  1'b1, 1'b0, 5'd0,  5'd10, 5'd2, 5'd2);
`ifdef PC_WRAP_EN
        step("inv_wrap",    1'b1, 1'b0, 5'd0,  5'd10, 5'd2, 5'd10);
        step("inv_after",   1'b1, 1'b0, 5'd0,  5'd10, 5'd2, 5'd11);
`else
        step("inv_nowrap",  1'b1, 1'b0, 5'd0,  5'd10, 5'd2, 5'd3);
        step("inv_after",   1'b1, 1'b0, 5'd0,  5'd10, 5'd2, 5'd4);
`endif

        // Asynchronous reset mid-run with a jump pending.
        step("pre_rst_9",   1'b1, 1'b1, 5'd9,  5'd0, 5'd31, 5'd9);
        @(posedge clk);
        #3;
        jump    = 5'd17;
        jump_en = 1'b1;
        rst     = 1'b1;
        #1;
        check("rst_async", pc, 5'd0);
        @(posedge clk);
        #1;
        check("rst_held_edge", pc, 5'd0);
        #2;
        rst = 1'b0;
        push("post_rst_jump", 5'd17);
        step("post_rst_inc", 1'b1, 1'b0, 5'd0, 5'd0, 5'd31, 5'd18);

        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter PC_W, default 5, giving the width of the instruction address.
REQ-002 The block SHALL have parameter RST_PC, default 0, giving the PC value loaded on reset.
REQ-003 clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wrap_top  input  PC_W  first address of the program window, i.e. the wrap target.
REQ-006 wrap_bottom  input  PC_W  last address of the program window; sequential advance from it wraps.
REQ-007 jump  input  PC_W  jump target address.
REQ-008 jump_en  input  1  when high, load jump instead of advancing sequentially.
REQ-009 pc_en  input  1  advance enable; when low, pc holds.
REQ-010 pc  output  PC_W  registered current program counter.

Function
REQ-011 pc SHALL be a register updated only on rising clk edges while rst is low.
REQ-012 pc_en=0 SHALL hold pc unchanged regardless of jump_en, jump and the wrap inputs.
REQ-013 pc_en=1 with jump_en=1 SHALL load pc <= jump on the next edge, with 1-cycle latency.
REQ-014 jump SHALL take priority over wrap: a jump issued while pc==wrap_bottom SHALL load jump.
REQ-015 pc_en=1, jump_en=0, pc==wrap_bottom SHALL load pc <= wrap_top (wrap feature compiled in).
REQ-016 pc_en=1, jump_en=0, pc!=wrap_bottom SHALL load pc <= pc+1 modulo 2^PC_W (31 -> 0 at PC_W=5).
REQ-017 A pc outside the window (pc > wrap_bottom or pc < wrap_top) SHALL keep incrementing modulo 2^PC_W until it equals wrap_bottom; no range clamping is applied.
REQ-018 wrap_top > wrap_bottom SHALL be legal and SHALL obey REQ-015/016 unchanged.
REQ-019 wrap_top, wrap_bottom and jump SHALL be sampled combinationally at the active edge; they are not latched internally.
REQ-020 No internal state other than pc SHALL exist.

Reset
REQ-021 rst high SHALL force pc to RST_PC immediately, independent of clk.
REQ-022 An rst asserted mid-run SHALL discard any pending jump or advance.
REQ-023 The first edge after rst deasserts SHALL apply REQ-012..016 normally.

Configuration
REQ-024 Macro PC_WRAP_EN defined: wrap behaviour of REQ-015 SHALL be active.
REQ-025 Macro PC_WRAP_EN undefined: wrap_top and wrap_bottom SHALL be ignored, and pc SHALL advance pc+1 modulo 2^PC_W except on jump.

Structure
REQ-026 A shared package pc_pkg SHALL hold PC_W, RST_PC and the address typedef pc_addr_t.
REQ-027 Next-address selection (hold/jump/wrap/increment) SHALL live in a combinational sub-module pc_next; program_counter SHALL contain only the register and reset.

Verification
REQ-028 Reset: assert rst with pc=9 -> pc=0 immediately, without waiting for a clock edge.
REQ-029 Free run: top=0, bottom=31, pc_en=1, jump_en=0 from reset -> pc steps 0,1,...,31,0.
REQ-030 Window: top=4, bottom=7, start pc=4 -> pc steps 5,6,7,4,5.
REQ-031 Jump: pc=3, jump_en=1, jump=12 -> pc=12 after one edge; with jump_en=0 it then steps to 13.
REQ-032 Stall and priority: pc_en=0 for 3 cycles at pc=6 -> pc stays 6; then pc=7=bottom with jump_en=1, jump=2 -> pc=2, not wrap_top.
REQ-033 Out of window: top=4, bottom=7, jump to 20 -> pc steps 21,...,31,0,...,7,4.
